// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/EX/MEM hazard inputs and stall/flush strobes between core and hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
);
    logic [ADDR_W-1:0] id_rs_x;
    logic [ADDR_W-1:0] id_rs_y;
    logic              id_uses_x;
    logic              id_uses_y;
    logic [ADDR_W-1:0] ex_WB_ADDR;
    logic              ex_RF_WR;
    logic [ADDR_W-1:0] mem_WB_ADDR;
    logic              mem_RF_WR;
    logic              ex_branch_taken;
    logic              ext_stall;
    logic              pc_stall;
    logic              if_id_stall;
    logic              if_id_flush;
    logic              id_ex_nop;
    logic              flushing;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    // Core side: supplies pipeline status, consumes strobes.
    modport master (
        output id_rs_x, id_rs_y, id_uses_x, id_uses_y,
        output ex_WB_ADDR, ex_RF_WR, mem_WB_ADDR, mem_RF_WR,
        output ex_branch_taken, ext_stall,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_nop, flushing,
        input  stall_cnt, flush_cnt
    );

    // Controller side.
    modport slave (
        input  id_rs_x, id_rs_y, id_uses_x, id_uses_y,
        input  ex_WB_ADDR, ex_RF_WR, mem_WB_ADDR, mem_RF_WR,
        input  ex_branch_taken, ext_stall,
        output pc_stall, if_id_stall, if_id_flush, id_ex_nop, flushing,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/bubble controller: RAW detection against EX/MEM, multi-cycle branch flush,
// and saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input logic                 clk,
    input logic                 rst,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef enum logic {StRun, StFlush} state_e;

    localparam logic [3:0]       FlReload = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    state_e           state_q;
    logic [3:0]       fl_left_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic [ADDR_W-1:0] rs_x, rs_y, ex_addr, mem_addr;
    logic              raw_hz;
    logic              pc_stall, if_id_stall, if_id_flush, id_ex_nop;

    assign rs_x     = bus.id_rs_x;
    assign rs_y     = bus.id_rs_y;
    assign ex_addr  = bus.ex_WB_ADDR;
    assign mem_addr = bus.mem_WB_ADDR;

    // RAW hazard and same-cycle strobe decode; reset and flush both inject bubbles.
    always_comb begin
        raw_hz = (bus.id_uses_x & ((bus.ex_RF_WR & (ex_addr == rs_x)) |
                                   (bus.mem_RF_WR & (mem_addr == rs_x)))) |
                 (bus.id_uses_y & ((bus.ex_RF_WR & (ex_addr == rs_y)) |
                                   (bus.mem_RF_WR & (mem_addr == rs_y))));
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_nop   = 1'b0;
        if (rst || bus.ex_branch_taken || (state_q == StFlush)) begin
            if_id_flush = 1'b1;
            id_ex_nop   = 1'b1;
        end else if (raw_hz || bus.ext_stall) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_nop   = 1'b1;
        end
    end

    // Flush FSM and saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            fl_left_q   <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (bus.ex_branch_taken) begin
                // A taken branch always restarts the squash window, even mid-flush.
                if (FLUSH_CYCLES > 1) begin
                    state_q   <= StFlush;
                    fl_left_q <= FlReload;
                end else begin
                    state_q   <= StRun;
                    fl_left_q <= 4'd0;
                end
            end else if (state_q == StFlush) begin
                fl_left_q <= fl_left_q - 4'd1;
                if (fl_left_q == 4'd1) begin
                    state_q <= StRun;
                end
            end
            // pc_stall is only ever raised in RUN, so no extra state qualifier needed.
            if (pc_stall && (stall_cnt_q != CntMax)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (if_id_flush && (flush_cnt_q != CntMax)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign bus.pc_stall    = pc_stall;
    assign bus.if_id_stall = if_id_stall;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_nop   = id_ex_nop;
    assign bus.flushing    = (state_q == StFlush);
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (FLUSH_CYCLES 2 and 3) against a
// cycle model that tracks "remaining squash cycles" and saturating counts.
module tb_pipeline_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_x, rs_y, ex_a, mem_a;
    logic       ux, uy, exw, memw, br, ext;

    int checks   = 0;
    int failures = 0;
    string phase = "init";

    int fc[2]   = '{2, 3};
    int cmax[2] = '{15, 63};
    int rem[2];
    int scnt[2];
    int fcnt[2];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.ADDR_W(5), .CNT_W(4)) bus0 ();
    pipeline_hazard_ctrl_if #(.ADDR_W(5), .CNT_W(6)) bus1 ();

    assign bus0.id_rs_x = rs_x;         assign bus1.id_rs_x = rs_x;
    assign bus0.id_rs_y = rs_y;         assign bus1.id_rs_y = rs_y;
    assign bus0.id_uses_x = ux;         assign bus1.id_uses_x = ux;
    assign bus0.id_uses_y = uy;         assign bus1.id_uses_y = uy;
    assign bus0.ex_WB_ADDR = ex_a;      assign bus1.ex_WB_ADDR = ex_a;
    assign bus0.ex_RF_WR = exw;         assign bus1.ex_RF_WR = exw;
    assign bus0.mem_WB_ADDR = mem_a;    assign bus1.mem_WB_ADDR = mem_a;
    assign bus0.mem_RF_WR = memw;       assign bus1.mem_RF_WR = memw;
    assign bus0.ex_branch_taken = br;   assign bus1.ex_branch_taken = br;
    assign bus0.ext_stall = ext;        assign bus1.ext_stall = ext;

    pipeline_hazard_ctrl #(.ADDR_W(5), .FLUSH_CYCLES(2), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );
    pipeline_hazard_ctrl #(.ADDR_W(5), .FLUSH_CYCLES(3), .CNT_W(6)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
        end
    endtask

    function automatic bit hazard();
        bit hx, hy;
        hx = ux && ((exw && ex_a == rs_x) || (memw && mem_a == rs_x));
        hy = uy && ((exw && ex_a == rs_y) || (memw && mem_a == rs_y));
        return hx || hy;
    endfunction

    // Compare both DUTs at the negedge, then advance the model at the posedge.
    task automatic step();
        bit fl, st;
        logic [31:0] o[7];
        logic [31:0] e[7];
        string nm[7] = '{"pc_stall", "if_id_stall", "if_id_flush", "id_ex_nop",
                         "flushing", "stall_cnt", "flush_cnt"};
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            fl = (rst == 1'b1) || br || (rem[k] > 0);
            st = !fl && (hazard() || ext);
            e[0] = 32'(st); e[1] = 32'(st); e[2] = 32'(fl); e[3] = 32'(fl || st);
            e[4] = 32'(rem[k] > 0); e[5] = 32'(scnt[k]); e[6] = 32'(fcnt[k]);
            if (k == 0) begin
                o[0] = 32'(bus0.pc_stall);    o[1] = 32'(bus0.if_id_stall);
                o[2] = 32'(bus0.if_id_flush); o[3] = 32'(bus0.id_ex_nop);
                o[4] = 32'(bus0.flushing);    o[5] = 32'(bus0.stall_cnt);
                o[6] = 32'(bus0.flush_cnt);
            end else begin
                o[0] = 32'(bus1.pc_stall);    o[1] = 32'(bus1.if_id_stall);
                o[2] = 32'(bus1.if_id_flush); o[3] = 32'(bus1.id_ex_nop);
                o[4] = 32'(bus1.flushing);    o[5] = 32'(bus1.stall_cnt);
                o[6] = 32'(bus1.flush_cnt);
            end
            for (int i = 0; i < 7; i++) chk($sformatf("dut%0d.%s", k, nm[i]), o[i], e[i]);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                rem[k] = 0; scnt[k] = 0; fcnt[k] = 0;
            end else begin
                fl = br || (rem[k] > 0);
                st = !fl && (hazard() || ext);
                if (st && scnt[k] < cmax[k]) scnt[k]++;
                if (fl && fcnt[k] < cmax[k]) fcnt[k]++;
                rem[k] = br ? fc[k] - 1 : (rem[k] > 0 ? rem[k] - 1 : 0);
            end
        end
        #1;
    endtask

    task automatic idle();
        rs_x = 0; rs_y = 0; ex_a = 0; mem_a = 0;
        ux = 0; uy = 0; exw = 0; memw = 0; br = 0; ext = 0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; step(); rst = 0;
    endtask

    initial begin
        rst = 1; idle();
        for (int k = 0; k < 2; k++) begin rem[k] = 0; scnt[k] = 0; fcnt[k] = 0; end
        @(posedge clk); #1;

        phase = "reset";
        for (int i = 0; i < 3; i++) begin
            rs_x = 5'($urandom); rs_y = 5'($urandom); ex_a = 5'($urandom); mem_a = 5'($urandom);
            {ux, uy, exw, memw, br, ext} = 6'($urandom);
            step();
            chk("rst_nop", 32'(bus0.id_ex_nop), 1);
        end
        rst = 0; idle(); step();
        chk("rst_scnt", 32'(bus0.stall_cnt), 0);
        chk("rst_flushing", 32'(bus0.flushing), 0);

        phase = "raw_x";
        do_reset();
        rs_x = 5; ux = 1; ex_a = 5; exw = 1; step();
        exw = 0; mem_a = 5; memw = 1; step();
        chk("scnt2", 32'(bus0.stall_cnt), 2);
        ux = 0; step();
        chk("no_use_pc_stall", 32'(bus0.pc_stall), 0);

        phase = "branch";
        do_reset();
        br = 1; step(); br = 0;
        chk("flushing_n1", 32'(bus0.flushing), 1);
        step();
        chk("flushing_n2", 32'(bus0.flushing), 0);
        step();
        chk("fcnt2", 32'(bus0.flush_cnt), 2);

        phase = "br_hz";
        do_reset();
        rs_y = 7; uy = 1; ex_a = 7; exw = 1; br = 1; step();
        br = 0; exw = 0; ext = 1; step();
        ext = 0; uy = 0; step();
        chk("scnt0", 32'(bus0.stall_cnt), 0);

        phase = "br_twice";
        do_reset();
        br = 1; step(); step(); br = 0; step(); step();
        chk("fcnt3", 32'(bus0.flush_cnt), 3);

        phase = "sat";
        do_reset();
        ext = 1;
        for (int i = 0; i < 20; i++) step();
        ext = 0;
        chk("sat4", 32'(bus0.stall_cnt), 15);
        chk("sat6", 32'(bus1.stall_cnt), 20);

        phase = "rst_mid_flush";
        do_reset();
        br = 1; step(); br = 0; rst = 1; step(); rst = 0;
        chk("flushing0", 32'(bus1.flushing), 0);
        chk("fcnt0", 32'(bus1.flush_cnt), 0);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            rs_x = 5'($urandom_range(0, 3)); rs_y = 5'($urandom_range(0, 3));
            ex_a = 5'($urandom_range(0, 3)); mem_a = 5'($urandom_range(0, 3));
            ux = 1'($urandom); uy = 1'($urandom); exw = 1'($urandom); memw = 1'($urandom);
            br = ($urandom_range(0, 7) == 0);
            ext = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 59) == 0);
            step();
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and bubble controller for the pipelined RAT core. Compares decode-stage source registers against in-flight destinations in EX and MEM, tracks multi-cycle flushes after taken branches, and drives the stall/flush strobes for the fetch stage and the `nop` input of the ID/EX control-vector register. It also keeps saturating performance counters of stall and flush cycles for debug readout.

## Interface
Parameters:
- ADDR_W, 5, register-file address width
- FLUSH_CYCLES, 2, number of cycles squashed per taken branch (1..15)
- CNT_W, 16, width of performance counters

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- id_rs_x  in  ADDR_W  decode-stage X source address
- id_rs_y  in  ADDR_W  decode-stage Y source address
- id_uses_x  in  1  decode instruction reads X
- id_uses_y  in  1  decode instruction reads Y
- ex_WB_ADDR  in  ADDR_W  EX-stage destination
- ex_RF_WR  in  1  EX-stage will write register file
- mem_WB_ADDR  in  ADDR_W  MEM-stage destination
- mem_RF_WR  in  1  MEM-stage will write register file
- ex_branch_taken  in  1  EX resolved a taken branch/call/ret this cycle
- ext_stall  in  1  external hold request (I/O wait)
- pc_stall  out  1  hold PC (no increment, no load)
- if_id_stall  out  1  hold IF/ID register
- if_id_flush  out  1  load IF/ID with bubble
- id_ex_nop  out  1  drives `nop` of the ID/EX control-vector register
- flushing  out  1  FSM in FLUSH state
- stall_cnt  out  CNT_W  cycles with data/external stall
- flush_cnt  out  CNT_W  cycles with flush asserted

## Operation
- Data hazard (raw_hz) = (id_uses_x & ((ex_RF_WR & ex_WB_ADDR==id_rs_x) | (mem_RF_WR & mem_WB_ADDR==id_rs_x))) | same for Y. No register is exempt (r0 is general-purpose).
- FSM states: RUN, FLUSH. Register `fl_left` 4 bits.
- RUN: if ex_branch_taken -> assert if_id_flush=1, id_ex_nop=1, pc_stall=0, if_id_stall=0; if FLUSH_CYCLES>1 go FLUSH with fl_left=FLUSH_CYCLES-1, else stay RUN. Else if raw_hz or ext_stall -> pc_stall=1, if_id_stall=1, id_ex_nop=1, if_id_flush=0. Else all strobes 0.
- FLUSH: if_id_flush=1, id_ex_nop=1, pc_stall=0, if_id_stall=0; raw_hz and ext_stall ignored. fl_left decrements; at fl_left==1 return to RUN. ex_branch_taken in FLUSH reloads fl_left=FLUSH_CYCLES-1 (stays FLUSH; if FLUSH_CYCLES==1, stays RUN path semantics: one cycle then RUN).
- Priority: rst > ex_branch_taken > FLUSH state > ext_stall/raw_hz.
- Counters: stall_cnt +1 each cycle pc_stall=1 in RUN; flush_cnt +1 each cycle if_id_flush=1. Both saturate at all-ones, never wrap.
- flushing = (state==FLUSH).

## Timing
- Strobes are combinational from inputs and current state (same-cycle response); FSM, fl_left, counters registered.
- During rst=1: id_ex_nop=1, if_id_flush=1, pc_stall=0, if_id_stall=0 (bubbles injected while reset held). On the edge with rst=1: state=RUN, fl_left=0, stall_cnt=0, flush_cnt=0, flushing=0 next cycle.
- Reset mid-flush: FLUSH abandoned at the next edge; counters cleared.
- Taken branch in cycle N: squash cycles N..N+FLUSH_CYCLES-1; RUN from N+FLUSH_CYCLES.
- Load/use on EX producer: stall lasts while the matching instruction is in EX or MEM (2 cycles for back-to-back dependency with no forwarding).
- Simultaneous ex_branch_taken and raw_hz: flush wins, no stall, stall_cnt not incremented.

## Test plan
- Reset: hold rst 3 cycles with random inputs -> id_ex_nop=1, if_id_flush=1, pc_stall=0 throughout; after release counters=0, flushing=0.
- RAW on X: id_rs_x=5, id_uses_x=1, ex_WB_ADDR=5, ex_RF_WR=1 one cycle then mem_WB_ADDR=5, mem_RF_WR=1 next -> pc_stall=if_id_stall=id_ex_nop=1 both cycles, stall_cnt=2; id_uses_x=0 same addresses -> no stall.
- Branch flush, FLUSH_CYCLES=2: ex_branch_taken pulse at cycle N -> if_id_flush=id_ex_nop=1 at N and N+1, flushing=1 at N+1 only, RUN at N+2, flush_cnt=2.
- Branch plus hazard simultaneously and ext_stall during FLUSH -> no pc_stall, stall_cnt unchanged.
- Second ex_branch_taken during FLUSH at N+1 -> flush extends through N+2, flush_cnt=3.
- Saturation, CNT_W=4: ext_stall held 20 cycles -> stall_cnt reaches 15 and holds; rst mid-flush -> state RUN, flushing=0 after the edge.
